// File: rtl/pkt_req_sched.sv
// Round-robin read-request scheduler with an outstanding-read credit pool and a flush/drain handshake.
// Optional PKT_REQ_SCHED_STAT_EN builds a 16-bit output-transfer counter shown on dbg_sig[31:16].
module pkt_req_sched #(
    parameter int NREQ    = 4,
    parameter int REQ_WID = 38,
    parameter int SRC_WID = 2,
    parameter int CREDIT  = 8,
    parameter int CWID    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_vld,
    output logic [NREQ-1:0]         req_rdy,
    input  logic [NREQ*REQ_WID-1:0] req_msg,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [REQ_WID-1:0]      out_msg,
    output logic [SRC_WID-1:0]      out_src,
    input  logic                    rsp_done,
    input  logic [NREQ-1:0]         cfg_src_en,
    input  logic                    cfg_flush,
    output logic                    flush_done,
    output logic [CWID-1:0]         credit_cnt,
    output logic [31:0]             dbg_sig
);
    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_DRAIN = 2'd1, ST_IDLE = 2'd2} state_t;

    localparam logic [CWID-1:0] CREDIT_FULL = CWID'(CREDIT);

    state_t               state_q, state_d;
    logic                 out_vld_q, out_vld_d;
    logic [REQ_WID-1:0]   out_msg_q, out_msg_d;
    logic [SRC_WID-1:0]   out_src_q, out_src_d;
    logic [SRC_WID-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CWID-1:0]      credit_q, credit_d;
    logic                 err_ovf_q, err_ovf_d;
    logic                 flush_done_q, flush_done_d;
    logic [31:0]          dbg_q, dbg_d;
    logic [15:0]          stat_d;

    logic [NREQ-1:0]      elig;
    logic                 win_found;
    logic [SRC_WID-1:0]   win_idx;
    logic                 grant_ok;
    logic                 grant;

    assign elig = req_vld & cfg_src_en;

    // Lowest rotation offset from rr_ptr wins, so scan offsets high to low.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (elig[(int'(rr_ptr_q) + k) % NREQ]) begin
                win_found = 1'b1;
                win_idx   = SRC_WID'((int'(rr_ptr_q) + k) % NREQ);
            end
        end
    end

    assign grant_ok = (state_q == ST_RUN) && !cfg_flush && (credit_q != '0) &&
                      (!out_vld_q || out_rdy);
    assign grant    = grant_ok && win_found;
    assign req_rdy  = grant ? (NREQ'(1) << win_idx) : '0;

    always_comb begin
        out_vld_d = out_vld_q;
        out_msg_d = out_msg_q;
        out_src_d = out_src_q;
        rr_ptr_d  = rr_ptr_q;
        credit_d  = credit_q;
        err_ovf_d = err_ovf_q;
        state_d   = state_q;

        if (grant) begin
            out_vld_d = 1'b1;
            out_msg_d = req_msg[int'(win_idx) * REQ_WID +: REQ_WID];
            out_src_d = win_idx;
            rr_ptr_d  = SRC_WID'((int'(win_idx) + 1) % NREQ);
        end else if (out_rdy) begin
            out_vld_d = 1'b0;
        end

        // A return against a full pool is dropped and flagged.
        case ({grant, rsp_done})
            2'b10:   credit_d = credit_q - 1'b1;
            2'b01: begin
                if (credit_q == CREDIT_FULL) err_ovf_d = 1'b1;
                else                         credit_d  = credit_q + 1'b1;
            end
            default: credit_d = credit_q;
        endcase

        case (state_q)
            ST_RUN:   if (cfg_flush) state_d = ST_DRAIN;
            ST_DRAIN: if (!out_vld_q && credit_q == CREDIT_FULL) state_d = ST_IDLE;
            ST_IDLE:  if (!cfg_flush) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase

        flush_done_d = (state_d == ST_IDLE);
        dbg_d = {stat_d, 8'(req_vld), 4'(credit_d), err_ovf_d, state_d, out_vld_d};
    end

`ifdef PKT_REQ_SCHED_STAT_EN
    logic [15:0] stat_q;
    assign stat_d = stat_q + 16'(out_vld_q & out_rdy);

    always_ff @(posedge clk) begin
        if (!rst) stat_q <= '0;
        else      stat_q <= stat_d;
    end
`else
    assign stat_d = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            out_vld_q    <= 1'b0;
            out_msg_q    <= '0;
            out_src_q    <= '0;
            rr_ptr_q     <= '0;
            credit_q     <= CREDIT_FULL;
            err_ovf_q    <= 1'b0;
            flush_done_q <= 1'b0;
            dbg_q        <= '0;
        end else begin
            state_q      <= state_d;
            out_vld_q    <= out_vld_d;
            out_msg_q    <= out_msg_d;
            out_src_q    <= out_src_d;
            rr_ptr_q     <= rr_ptr_d;
            credit_q     <= credit_d;
            err_ovf_q    <= err_ovf_d;
            flush_done_q <= flush_done_d;
            dbg_q        <= dbg_d;
        end
    end

    assign out_vld    = out_vld_q;
    assign out_msg    = out_msg_q;
    assign out_src    = out_src_q;
    assign credit_cnt = credit_q;
    assign flush_done = flush_done_q;
    assign dbg_sig    = dbg_q;
endmodule
